// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, word width, FIPS-197 S-box and GF(2^8) doubling.
// Also used by the inverse-cipher logic in aes_decryption.
package aes_pkg;

    localparam int AES_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Entry 0 sits in the most significant byte, so SBOX_TABLE[b] is S(b).
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: independent S-box substitution of each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [AES_WORD_W-1:0] word_i,
    output logic [AES_WORD_W-1:0] word_o
);

    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_expansion.sv
// Multicycle AES key schedule: one round-key word per cycle into a held chain register.
// Word w[j] of the chain lives at packed index j, so w[0] lands in the MSBs of key_chain_o.
module aes_key_expansion
    import aes_pkg::*;
#(
    parameter  int nk_p    = 8,
    localparam int nr_p    = nk_p + 6,
    localparam int chain_w = 128 * (nr_p + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [32*nk_p-1:0]    key_i,
    input  logic                  v_i,
    output logic                  ready_o,
    output logic [chain_w-1:0]    key_chain_o,
    output logic                  v_o,
    input  logic                  yumi_i
);

    localparam int         TOTAL_WORDS = 4 * (nr_p + 1);
    localparam logic [5:0] NK_IDX      = 6'(nk_p);
    localparam logic [5:0] LAST_IDX    = 6'(TOTAL_WORDS - 1);
    localparam logic [2:0] LAST_PHASE  = 3'(nk_p - 1);

    state_e                                  state_q, state_d;
    logic [5:0]                              wordIdx_q, wordIdx_d;
    logic [2:0]                              phase_q, phase_d;
    logic [7:0]                              rcon_q, rcon_d;
    logic [0:TOTAL_WORDS-1][AES_WORD_W-1:0]  chain_q, chain_d;

    logic [AES_WORD_W-1:0] prevWord, oldWord, subIn, subOut, newWord;

    // phase_q tracks i % nk_p incrementally so no divider is needed.
    always_comb begin
        prevWord = chain_q[wordIdx_q - 6'd1];
        oldWord  = chain_q[wordIdx_q - NK_IDX];
        subIn    = (phase_q == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
    end

    aes_sub_word u_sub_word (
        .word_i (subIn),
        .word_o (subOut)
    );

    always_comb begin
        state_d   = state_q;
        wordIdx_d = wordIdx_q;
        phase_d   = phase_q;
        rcon_d    = rcon_q;
        chain_d   = chain_q;
        ready_o   = 1'b0;
        v_o       = 1'b0;
        newWord   = oldWord ^ prevWord;

        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) begin
                    chain_d[0:nk_p-1] = key_i;
                    wordIdx_d         = NK_IDX;
                    phase_d           = 3'd0;
                    rcon_d            = 8'h01;
                    state_d           = EXPAND;
                end
            end
            EXPAND: begin
                if (phase_q == 3'd0) begin
                    newWord = oldWord ^ subOut ^ {rcon_q, 24'h0};
                    rcon_d  = xtime(rcon_q);
                end else if (nk_p == 8 && phase_q == 3'd4) begin
                    newWord = oldWord ^ subOut;
                end
                chain_d[wordIdx_q] = newWord;
                phase_d = (phase_q == LAST_PHASE) ? 3'd0 : phase_q + 3'd1;
                // The index stops at the last word rather than running past the chain.
                if (wordIdx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    wordIdx_d = wordIdx_q + 6'd1;
                end
            end
            DONE: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            wordIdx_q <= '0;
            phase_q   <= '0;
            rcon_q    <= 8'h01;
            chain_q   <= '0;
        end else begin
            state_q   <= state_d;
            wordIdx_q <= wordIdx_d;
            phase_q   <= phase_d;
            rcon_q    <= rcon_d;
            chain_q   <= chain_d;
        end
    end

    assign key_chain_o = chain_q;

endmodule
